// File: rtl/noobs_mem_arb_pkg.sv
// Shared types and helpers for the noobs memory arbiter.
package noobs_mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam int RR_FIXED = 0;
   localparam int RR_ROUND = 1;

   // Smallest r with 2**r >= value.
   function automatic int noobs_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/noobs_mem_arb_if.sv
// Requester and memory bus bundle for the noobs memory arbiter.
interface noobs_mem_arb_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int NUM_CH = 2
);
   logic [NUM_CH-1:0]        ch_req;
   logic [NUM_CH-1:0]        ch_wr;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH*DATA_W-1:0] ch_wdata;
   logic [NUM_CH-1:0]        ch_gnt;
   logic [NUM_CH-1:0]        ch_done;
   logic [NUM_CH-1:0]        ch_err;
   logic [DATA_W-1:0]        ch_rdata;
   logic                     mem_en;
   logic                     mem_rd;
   logic                     mem_wr;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wdata;
   logic [DATA_W-1:0]        mem_rdata;
   logic                     mem_rdy;
   logic                     busy;

   // Arbiter side.
   modport slave (
      input  ch_req, ch_wr, ch_addr, ch_wdata, mem_rdata, mem_rdy,
      output ch_gnt, ch_done, ch_err, ch_rdata,
             mem_en, mem_rd, mem_wr, mem_addr, mem_wdata, busy
   );

   // Requesters plus memory, i.e. everything around the arbiter.
   modport master (
      output ch_req, ch_wr, ch_addr, ch_wdata, mem_rdata, mem_rdy,
      input  ch_gnt, ch_done, ch_err, ch_rdata,
             mem_en, mem_rd, mem_wr, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/noobs_rr_pick.sv
// Combinational winner selection: fixed priority (ch0 first) or
// round-robin starting just above the previous winner.
module noobs_rr_pick
   import noobs_mem_arb_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = 1
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [IDX_W-1:0]  i_last,
   input  logic              i_mode,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [IDX_W-1:0]  o_idx
);

   logic w_found;
   int   w_best;
   int   w_dist;

   // Each channel gets a distance from the search start; the nearest active one wins.
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_best  = NUM_CH;
      w_dist  = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_dist = i_mode ? ((k + 2 * NUM_CH - int'(i_last) - 1) % NUM_CH) : k;
         if (i_req[k] && (w_dist < w_best)) begin
            w_best  = w_dist;
            o_idx   = IDX_W'(k);
            w_found = 1'b1;
         end
      end
      for (int k = 0; k < NUM_CH; k++) begin
         o_gnt[k] = w_found && (o_idx == IDX_W'(k));
      end
   end

endmodule

// File: rtl/noobs_mem_arb.sv
// Multi-channel single-port memory arbiter with access timeout.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | waiting for a request; arbitrates and grants
//   ST_ACCESS | memory access driven, waiting for mem_rdy/timeout
//   ST_RESP   | pulse done or err to the winner, record winner
module noobs_mem_arb
   import noobs_mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int NUM_CH  = 2,
   parameter int RR_MODE = 0,
   parameter int TMO_CYC = 255
) (
   input  logic           clk,
   input  logic           reset,
   noobs_mem_arb_if.slave bus
);

   localparam int IDX_W = noobs_clog2(NUM_CH);
   localparam int TMO_W = noobs_clog2(TMO_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(TMO_CYC);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);

   state_t              r_state;
   logic [IDX_W-1:0]    r_last;
   logic [IDX_W-1:0]    r_win_idx;
   logic [NUM_CH-1:0]   r_win_oh;
   logic                r_wr_l;
   logic                r_tmo_l;
   logic [TMO_W-1:0]    r_tmo_cnt;
   logic [NUM_CH-1:0]   r_gnt;
   logic [NUM_CH-1:0]   r_done;
   logic [NUM_CH-1:0]   r_err;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_mem_en;
   logic                r_mem_rd;
   logic                r_mem_wr;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_busy;

   logic                w_mode;
   logic [NUM_CH-1:0]   w_win_oh;
   logic [IDX_W-1:0]    w_win_idx;
   logic                w_sel_wr;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic [TMO_W-1:0]    w_tmo_next;

   assign w_mode     = (RR_MODE == RR_ROUND);
   assign w_sel_wr   = |(bus.ch_wr & w_win_oh);
   assign w_tmo_next = r_tmo_cnt + 1'b1;

   noobs_rr_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .i_req  (bus.ch_req),
      .i_last (r_last),
      .i_mode (w_mode),
      .o_gnt  (w_win_oh),
      .o_idx  (w_win_idx)
   );

   // Mux the winning channel's address and write data out of the packed buses.
   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_win_oh[k]) begin
            w_sel_addr  = w_sel_addr  | bus.ch_addr[k*ADDR_W +: ADDR_W];
            w_sel_wdata = w_sel_wdata | bus.ch_wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_last      <= LAST_RST;
         r_win_idx   <= '0;
         r_win_oh    <= '0;
         r_wr_l      <= 1'b0;
         r_tmo_l     <= 1'b0;
         r_tmo_cnt   <= '0;
         r_gnt       <= '0;
         r_done      <= '0;
         r_err       <= '0;
         r_rdata     <= '0;
         r_mem_en    <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_gnt  <= '0;
         r_done <= '0;
         r_err  <= '0;
         case (r_state)
            ST_IDLE: begin
               if (|bus.ch_req) begin
                  r_win_oh    <= w_win_oh;
                  r_win_idx   <= w_win_idx;
                  r_wr_l      <= w_sel_wr;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
                  r_gnt       <= w_win_oh;
                  r_mem_en    <= 1'b1;
                  r_mem_rd    <= !w_sel_wr;
                  r_mem_wr    <= w_sel_wr;
                  r_tmo_cnt   <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // A ready on the final allowed cycle still wins over the timeout.
               if (bus.mem_rdy) begin
                  if (!r_wr_l) r_rdata <= bus.mem_rdata;
                  r_tmo_l  <= 1'b0;
                  r_mem_en <= 1'b0;
                  r_mem_rd <= 1'b0;
                  r_mem_wr <= 1'b0;
                  r_state  <= ST_RESP;
               end else begin
                  r_tmo_cnt <= w_tmo_next;
                  if (w_tmo_next == TMO_END) begin
                     r_tmo_l  <= 1'b1;
                     r_mem_en <= 1'b0;
                     r_mem_rd <= 1'b0;
                     r_mem_wr <= 1'b0;
                     r_state  <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (r_tmo_l) r_err  <= r_win_oh;
               else         r_done <= r_win_oh;
               r_last  <= r_win_idx;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ch_gnt    = r_gnt;
   assign bus.ch_done   = r_done;
   assign bus.ch_err    = r_err;
   assign bus.ch_rdata  = r_rdata;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_rd    = r_mem_rd;
   assign bus.mem_wr    = r_mem_wr;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.busy      = r_busy;

   // Memory strobes must be exclusive and idle with enable low; grants one-hot or zero.
   a_mem_ctl: assert property (@(posedge clk) disable iff (reset)
      !(r_mem_en && r_mem_rd && r_mem_wr) && (r_mem_en || !(r_mem_rd || r_mem_wr)));
   a_gnt_oh: assert property (@(posedge clk) disable iff (reset) $onehot0(r_gnt));

endmodule

// File: doc/noobs_mem_arb.md
NOOBS_MEM_ARB -- requirements
Module: noobs_mem_arb

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 12, address width.
- DATA_W, 8, data width.
- NUM_CH, 2, requester channel count, range 2..8.
- RR_MODE, 0, 0 = fixed priority with ch0 highest, 1 = round-robin.
- TMO_CYC, 255, mem_rdy timeout in cycles, range 1..2^16-1.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- ch_req, in, NUM_CH, per-channel request.
- ch_wr, in, NUM_CH, 1 = write, 0 = read.
- ch_addr, in, NUM_CH*ADDR_W, packed addresses; ch c at [c*ADDR_W +: ADDR_W].
- ch_wdata, in, NUM_CH*DATA_W, packed write data.
- ch_gnt, out, NUM_CH, one-hot grant pulse.
- ch_done, out, NUM_CH, one-hot completion pulse.
- ch_err, out, NUM_CH, one-hot timeout pulse.
- ch_rdata, out, DATA_W, read data, valid with ch_done of a read.
- mem_en, out, 1, memory enable.
- mem_rd, out, 1, memory read.
- mem_wr, out, 1, memory write.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data.
- mem_rdy, in, 1, memory completes the access this cycle.
- busy, out, 1, high when state is not IDLE.

Function
REQ-003 State machine IDLE, ACCESS, RESP; all outputs registered.
REQ-004 IDLE: if any ch_req is high, select winner w, latch ch_wr[w], ch_addr[w] and ch_wdata[w], pulse ch_gnt[w] for one cycle, and enter ACCESS; otherwise stay in IDLE.
REQ-005 Requester holds req, wr, addr and wdata stable until it sees gnt; it may drop req the cycle after gnt.
REQ-006 Fixed mode: w = lowest-index active request.
REQ-007 Round-robin mode: w = first active request at or above last_winner+1, with wrap-around modulo NUM_CH.
REQ-008 ACCESS: mem_en = 1, mem_rd = !wr_l, mem_wr = wr_l, and mem_addr/mem_wdata come from the latched values.
REQ-009 mem_rd and mem_wr are never both 1, and both are 0 whenever mem_en = 0.
REQ-010 ACCESS with mem_rdy = 1: capture mem_rdata into ch_rdata if a read, drop mem_en/mem_rd/mem_wr, and enter RESP.
REQ-011 RESP: pulse ch_done[w] for one cycle, update last_winner to w, and return to IDLE.
REQ-012 Minimum latency: req at cycle N gives gnt at N+1, mem_en from N+1, mem_rdy sampled at N+1 gives done at N+3.
REQ-013 Back-to-back: a new grant is issued in the cycle after RESP, so arbitration runs once per transaction.
REQ-014 Timeout: a counter of width clog2(TMO_CYC+1) increments each ACCESS cycle without mem_rdy.
REQ-015 When the count reaches TMO_CYC without mem_rdy: drop mem_en, pulse ch_err[w] in RESP instead of ch_done[w], leave ch_rdata unchanged, and update last_winner.
REQ-016 The timeout counter clears on every entry into ACCESS.
REQ-017 mem_rdy is ignored outside ACCESS.
REQ-018 mem_rdy arriving in the same cycle the count reaches TMO_CYC counts as success, not timeout.
REQ-019 Requests arriving during ACCESS or RESP are not lost; they are evaluated in the next IDLE provided req is still held.
REQ-020 Simultaneous requests on every channel are served in priority order (fixed) or rotation order (round-robin), one grant per transaction.
REQ-021 Across consecutive grants with all channels requesting, ch_gnt is one-hot or zero in every cycle.

Reset
REQ-022 While reset = 1 at a clk edge:
- state = IDLE.
- ch_gnt = ch_done = ch_err = 0, ch_rdata = 0.
- mem_en = mem_rd = mem_wr = 0, mem_addr = 0, mem_wdata = 0, busy = 0.
- last_winner = NUM_CH-1, so ch0 is first in round-robin.
- timeout counter = 0.
REQ-023 Reset asserted mid-ACCESS abandons the transaction; no done or err pulse is emitted for it.

Structure
REQ-024 A shared package holds the state enumeration (IDLE/ACCESS/RESP), the RR_MODE encodings, and a clog2 function.
REQ-025 A single sub-module, noobs_rr_pick, is combinational: it takes req, last_winner and mode and produces a one-hot winner plus its index.
REQ-026 An assertion fires if mem_en & mem_rd & mem_wr, or if ch_gnt is not one-hot-or-zero.

Verification
REQ-027 The bench covers these directed scenarios:
- Fixed mode, ch1 read 0x123, mem_rdy at first ACCESS cycle, mem_rdata = 0xA5 -> gnt[1] at N+1, done[1] at N+3, ch_rdata = 0xA5.
- Fixed mode, ch0 and ch1 request together, each write (0x010, 0x11) and (0x020, 0x22) -> ch0 served first, then ch1; memory sees writes in that order.
- RR_MODE = 1, NUM_CH = 4, all four requesting continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- TMO_CYC = 5, mem_rdy held low -> mem_en high for exactly 5 cycles, err[w] pulses, no done, next request served normally.
- mem_rdy arriving on cycle 5 with TMO_CYC = 5 -> done pulses, no err.
- Reset asserted during ACCESS with a wait-stated memory -> all outputs at reset values next cycle, no done/err, a subsequent ch0 read completes normally.
